psram_qpi_model: RTL and testbench
==================================

# psram_qpi_model

Parametrised, synthesizable QSPI/QPI PSRAM device model that replaces the DPI-backed PSRAM behavioural model in simulation and FPGA builds. It holds its own byte array and oversamples the serial bus (`sck`, `ce_n`, `dio`) with a fast system clock. It supports 0xEB quad read with a configurable wait count, 0x38 quad write with burst length bounded only by `ce_n`, QPI mode entry/exit (0x35/0xF5), and wrapped bursts. It sits on the SoC PSRAM controller's pad side.

## Interface
- `DEPTH_BYTES`, 4194304: array size in bytes; must be a power of two. `AW = clog2(DEPTH_BYTES)`.
- `WAIT_CYCLES`, 6: `sck` rising edges between the last address nibble and the first read data nibble.
- `WRAP_BYTES`, 0: burst wrap boundary in bytes (power of two). 0 means linear, wrapping modulo `DEPTH_BYTES`.
- `clock`  in  1: system clock; frequency must be ≥ 4× `sck`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sck`  in  1: serial clock, synchronous to `clock` (no synchroniser).
- `ce_n`  in  1: chip enable, active-low; frames each transaction.
- `dio_i`  in  4: sampled data lines.
- `dio_o`  out  4: driven data lines.
- `dio_oe`  out  1: output enable for all four lines.
- `qpi_mode`  out  1: 1 = command phase takes 2 nibbles on `dio_i[3:0]`.
- `err`  out  1: sticky unsupported-command flag, cleared only by reset.

## Operation
- Edge detect: `sck_q` is registered every `clock`. `rise = sck & ~sck_q & ~ce_n`. All protocol actions happen on a `clock` edge where `rise` is true.
- `ce_n` high (sampled) forces state to CMD and clears all counters and the partial byte. `qpi_mode`, `err` and array contents are kept.
- States: CMD, ADDR, WAIT, READ, WRITE, IGNORE.
- CMD
  - SPI mode: shift in `dio_i[0]` MSB first over 8 rises.
  - QPI mode: shift in `dio_i` high nibble first over 2 rises.
  - On completion: 0xEB or 0x38 → ADDR. 0x35 → set `qpi_mode`, go to IGNORE. 0xF5 → clear `qpi_mode`, go to IGNORE. Any other value → set `err`, go to IGNORE.
- ADDR: 6 rises, 4 bits each, MSB nibble first (24-bit address). Bits above `AW` are ignored (aliasing). Then EB → WAIT, 38 → WRITE.
- WAIT: count `WAIT_CYCLES` rises, then READ.
- READ: `dio_oe` = 1. Each byte is sent as high nibble then low nibble, one nibble per rise. The pointer advances after each low nibble.
- WRITE: high nibble is captured first. On the low-nibble rise the full byte is committed to `mem[ptr]` and the pointer advances.
- Pointer increment:
  - `WRAP_BYTES` = 0: `ptr+1 mod DEPTH_BYTES`.
  - Otherwise: `{ptr[AW-1:log2(WRAP)], ptr[log2(WRAP)-1:0]+1}`, i.e. only the low bits wrap.
- IGNORE: no response until `ce_n` goes high. `dio_oe` = 0.
- The array is not reset. Its contents are undefined until written.

## Timing
- Reset values: state CMD, `dio_o` = 0, `dio_oe` = 0, `qpi_mode` = 0, `err` = 0.
- Every registered output updates exactly 1 `clock` after the `clock` edge that sees `rise`.
- `dio_oe` rises on the same `clock` edge that commits the last WAIT rise, together with the first data nibble (mem[addr][7:4]). The controller samples it on the next `sck` rise.
- Each subsequent nibble is updated 1 `clock` after each rise.
- A write commit is visible to a read issued in a later transaction. A partial byte (only the high nibble received) at `ce_n` high is discarded.
- `ce_n` rising mid-READ: `dio_oe` drops on the first `clock` edge with `ce_n` sampled high.
- `reset_n` low at any time: all state returns to reset values immediately. The array is preserved.

## Test plan
- SPI-mode write, then read back:
  - Write: 0x38, addr 0x000010, bytes 11 22 33 44, then `ce_n` high.
  - Read: 0xEB, addr 0x000010, 6 wait rises, 8 rises.
  - Required: `dio_o` = 1,1,2,2,3,3,4,4.
- QPI mode:
  - Send 0x35 → `qpi_mode` = 1.
  - Send 0xEB as 2 nibbles, then a read → same data as above.
  - Send 0xF5 → `qpi_mode` = 0.
- Wrap, with `WRAP_BYTES` = 4 and mem[0x10..0x13] = 11 22 33 44: read from 0x000013 for 3 bytes → 44 11 22.
- Unsupported command 0x03:
  - `err` = 1; `dio_oe` stays 0 for 20 further rises.
  - The next 0xEB transaction still reads correctly; `err` remains 1.
- Write abort: 0x38 at 0x20, send nibbles A,B,C, then `ce_n` high. Read back → mem[0x20] = 0xAB, mem[0x21] unchanged.
- Reset mid-READ: drive `reset_n` low after 3 data nibbles → `dio_oe` = 0 asynchronously, `qpi_mode` = 0. A re-read after reset returns the original data.

Source files
------------

// File: rtl/psram_qpi_model.sv
// psram_qpi_model: synthesizable QSPI/QPI PSRAM device model with its own byte array.
// Oversamples the serial bus with the system clock. It supports 0xEB quad read,
// 0x38 quad write, QPI entry/exit (0x35/0xF5) and optional wrapped bursts.
// Ports:
//   clock, reset_n      system clock, async active-low reset
//   sck, ce_n, dio_i    serial bus from the controller (sck synchronous to clock)
//   dio_o, dio_oe       read data nibble and shared output enable
//   qpi_mode            1 = command phase uses 2 nibbles on dio_i[3:0]
//   err                 sticky unsupported-command flag
// WAIT_CYCLES must be at least 1.
module psram_qpi_model #(
  parameter int unsigned DEPTH_BYTES = 4194304,
  parameter int unsigned WAIT_CYCLES = 6,
  parameter int unsigned WRAP_BYTES  = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] dio_i,
  output logic [3:0] dio_o,
  output logic       dio_oe,
  output logic       qpi_mode,
  output logic       err
);

  localparam int unsigned AW    = $clog2(DEPTH_BYTES);
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 8);
  // Bits of the pointer that increment; the rest stay fixed inside a wrap block.
  localparam logic [AW-1:0] WRAP_MASK = (WRAP_BYTES == 0) ? {AW{1'b1}} : AW'(WRAP_BYTES - 1);

  localparam logic [7:0] CMD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;
  localparam logic [7:0] CMD_QPI   = 8'h35;
  localparam logic [7:0] CMD_SPI   = 8'hF5;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_READ,
    S_WRITE,
    S_IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic              sck_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [19:0]       addr_q, addr_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              lo_q, lo_d;
  logic [3:0]        wbuf_q, wbuf_d;
  logic              is_rd_q, is_rd_d;
  logic [3:0]        dio_o_d;
  logic              dio_oe_d, qpi_mode_d, err_d;

  logic              rise;
  logic [7:0]        cmd_shift;
  logic              cmd_last;
  logic [23:0]       addr_shift;
  logic [AW-1:0]     ptr_inc;
  logic [AW-1:0]     rd_addr;
  logic [7:0]        rd_byte;
  logic              mem_we;

  logic [7:0] mem [DEPTH_BYTES];

  assign rise       = sck & ~sck_q & ~ce_n;
  assign cmd_shift  = qpi_mode ? {cmd_q[3:0], dio_i} : {cmd_q[6:0], dio_i[0]};
  assign cmd_last   = qpi_mode ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(7));
  assign addr_shift = {addr_q, dio_i};
  assign ptr_inc    = (ptr_q & ~WRAP_MASK) | ((ptr_q + AW'(1)) & WRAP_MASK);
  // While the low nibble is on the bus the next fetch is the following byte.
  assign rd_addr    = lo_q ? ptr_inc : ptr_q;
  assign rd_byte    = mem[rd_addr];
  assign mem_we     = rise && (state_q == S_WRITE) && lo_q;

  // Array: never reset, written on the low-nibble rise of each write byte.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[ptr_q] <= {wbuf_q, dio_i};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_CMD;
      sck_q    <= 1'b0;
      cnt_q    <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      ptr_q    <= '0;
      lo_q     <= 1'b0;
      wbuf_q   <= '0;
      is_rd_q  <= 1'b0;
      dio_o    <= '0;
      dio_oe   <= 1'b0;
      qpi_mode <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      sck_q    <= sck;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      ptr_q    <= ptr_d;
      lo_q     <= lo_d;
      wbuf_q   <= wbuf_d;
      is_rd_q  <= is_rd_d;
      dio_o    <= dio_o_d;
      dio_oe   <= dio_oe_d;
      qpi_mode <= qpi_mode_d;
      err      <= err_d;
    end
  end

  // Protocol next-state and outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    ptr_d      = ptr_q;
    lo_d       = lo_q;
    wbuf_d     = wbuf_q;
    is_rd_d    = is_rd_q;
    dio_o_d    = dio_o;
    dio_oe_d   = dio_oe;
    qpi_mode_d = qpi_mode;
    err_d      = err;

    if (ce_n) begin
      state_d  = S_CMD;
      cnt_d    = '0;
      cmd_d    = '0;
      lo_d     = 1'b0;
      wbuf_d   = '0;
      dio_oe_d = 1'b0;
    end else if (rise) begin
      case (state_q)
        S_CMD: begin
          cmd_d = cmd_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cmd_last) begin
            cnt_d = '0;
            case (cmd_shift)
              CMD_READ:  begin state_d = S_ADDR; is_rd_d = 1'b1; end
              CMD_WRITE: begin state_d = S_ADDR; is_rd_d = 1'b0; end
              CMD_QPI:   begin state_d = S_IGNORE; qpi_mode_d = 1'b1; end
              CMD_SPI:   begin state_d = S_IGNORE; qpi_mode_d = 1'b0; end
              default:   begin state_d = S_IGNORE; err_d = 1'b1; end
            endcase
          end
        end
        S_ADDR: begin
          addr_d = addr_shift[19:0];
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(5)) begin
            cnt_d   = '0;
            ptr_d   = AW'(addr_shift);  // upper address bits alias
            state_d = is_rd_q ? S_WAIT : S_WRITE;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
            cnt_d    = '0;
            state_d  = S_READ;
            dio_oe_d = 1'b1;
            dio_o_d  = rd_byte[7:4];
          end
        end
        S_READ: begin
          if (!lo_q) begin
            dio_o_d = rd_byte[3:0];
            lo_d    = 1'b1;
          end else begin
            ptr_d   = ptr_inc;
            dio_o_d = rd_byte[7:4];
            lo_d    = 1'b0;
          end
        end
        S_WRITE: begin
          if (!lo_q) begin
            wbuf_d = dio_i;
            lo_d   = 1'b1;
          end else begin
            ptr_d = ptr_inc;
            lo_d  = 1'b0;
          end
        end
        S_IGNORE: dio_oe_d = 1'b0;
        default:  state_d = S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_qpi_model.sv
// Bench for psram_qpi_model: a linear instance and a 4-byte-wrap instance share one bus.
// A transaction-level model (byte arrays plus burst address arithmetic) sets the
// expected outputs after each sck rise; one negedge process compares them every cycle.
module tb_psram_qpi_model;
  localparam int DEPTH = 4096;
  localparam int WAITC = 6;
  localparam int WRAPB = 4;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       sck     = 1'b0;
  logic       ce_n    = 1'b1;
  logic [3:0] dio_i   = 4'h0;
  logic [3:0] dio_o_l, dio_o_w;
  logic       oe_l, oe_w, qpi_l, qpi_w, err_l, err_w;

  always #5 clock = ~clock;

  psram_qpi_model #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WAITC), .WRAP_BYTES(0)) u_lin (
    .clock(clock), .reset_n(reset_n), .sck(sck), .ce_n(ce_n), .dio_i(dio_i),
    .dio_o(dio_o_l), .dio_oe(oe_l), .qpi_mode(qpi_l), .err(err_l));

  psram_qpi_model #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WAITC), .WRAP_BYTES(WRAPB)) u_wrp (
    .clock(clock), .reset_n(reset_n), .sck(sck), .ce_n(ce_n), .dio_i(dio_i),
    .dio_o(dio_o_w), .dio_oe(oe_w), .qpi_mode(qpi_w), .err(err_w));

  // Model state: index 0 = linear device, 1 = wrapping device.
  logic [7:0] mm [2][DEPTH];
  bit         mv [2][DEPTH];
  logic       exp_oe  = 1'b0;
  logic       exp_qpi = 1'b0;
  logic       exp_err = 1'b0;
  logic [3:0] exp_nib [2];
  bit         exp_nv  [2];
  bit         chk_en  = 1'b0;
  logic [3:0] cap [2][16];
  logic [3:0] last_l, last_w;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte address of burst element k for each device.
  function automatic int maddr(input int inst, input int base, input int k);
    if (inst == 0) return (base + k) % DEPTH;
    return (base & ~(WRAPB - 1)) | ((base + k) & (WRAPB - 1));
  endfunction

  // Nibble k of a read burst: even = high nibble, odd = low nibble.
  task automatic set_exp(input int base, input int k);
    int a;
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      a = maddr(i, base, k / 2);
      b = mm[i][a];
      exp_nv[i]  = mv[i][a];
      exp_nib[i] = (k % 2 == 0) ? b[7:4] : b[3:0];
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("oe_lin",   4'(oe_l),  4'(exp_oe));
      check("oe_wrap",  4'(oe_w),  4'(exp_oe));
      check("qpi_lin",  4'(qpi_l), 4'(exp_qpi));
      check("qpi_wrap", 4'(qpi_w), 4'(exp_qpi));
      check("err_lin",  4'(err_l), 4'(exp_err));
      check("err_wrap", 4'(err_w), 4'(exp_err));
      if (exp_oe && exp_nv[0]) check("dio_lin",  dio_o_l, exp_nib[0]);
      if (exp_oe && exp_nv[1]) check("dio_wrap", dio_o_w, exp_nib[1]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One sck period of 4 clocks; returns just after the clock edge that sees the rise.
  task automatic sck_rise(input logic [3:0] nib);
    tick();
    dio_i = nib;
    sck   = 1'b0;
    tick();
    tick();
    last_l = dio_o_l;
    last_w = dio_o_w;
    sck    = 1'b1;
    tick();
  endtask

  task automatic begin_txn();
    tick();
    ce_n = 1'b0;
    tick();
  endtask

  task automatic end_txn();
    tick();
    sck  = 1'b0;
    ce_n = 1'b1;
    tick();
    exp_oe = 1'b0;
    tick();
  endtask

  task automatic send_cmd(input logic [7:0] c);
    if (exp_qpi) begin
      sck_rise(c[7:4]);
      sck_rise(c[3:0]);
    end else begin
      for (int j = 7; j >= 0; j--) sck_rise({3'b101, c[j]});
    end
    case (c)
      8'h35:        exp_qpi = 1'b1;
      8'hF5:        exp_qpi = 1'b0;
      8'hEB, 8'h38: ;
      default:      exp_err = 1'b1;
    endcase
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int j = 5; j >= 0; j--) sck_rise(a[4*j +: 4]);
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [31:0] data, input int n,
                          input bit partial, input logic [3:0] pnib);
    int base;
    logic [7:0] b;
    base = int'(addr) % DEPTH;
    begin_txn();
    send_cmd(8'h38);
    send_addr(addr);
    for (int k = 0; k < n; k++) begin
      b = data[8*(n-1-k) +: 8];
      sck_rise(b[7:4]);
      sck_rise(b[3:0]);
      for (int i = 0; i < 2; i++) begin
        mm[i][maddr(i, base, k)] = b;
        mv[i][maddr(i, base, k)] = 1'b1;
      end
    end
    if (partial) sck_rise(pnib);
    end_txn();
  endtask

  // abort_nib > 0 pulls reset_n low after that many data nibbles.
  task automatic do_read(input logic [23:0] addr, input int n, input int abort_nib);
    int base;
    base = int'(addr) % DEPTH;
    begin_txn();
    send_cmd(8'hEB);
    send_addr(addr);
    for (int w = 0; w < WAITC; w++) sck_rise(4'($urandom));
    exp_oe = 1'b1;
    set_exp(base, 0);
    for (int j = 0; j < 2 * n; j++) begin
      sck_rise(4'($urandom));
      cap[0][j] = last_l;
      cap[1][j] = last_w;
      set_exp(base, j + 1);
      if (abort_nib == j + 1) begin
        reset_n = 1'b0;
        exp_oe  = 1'b0;
        exp_qpi = 1'b0;
        exp_err = 1'b0;
        #1;
        check("rst_async_oe",  4'(oe_l),  4'h0);
        check("rst_async_qpi", 4'(qpi_l), 4'h0);
        tick();
        ce_n = 1'b1;
        sck  = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        return;
      end
    end
    end_txn();
  endtask

  task automatic check_burst(input string name, input int inst, input int n, input logic [31:0] lit);
    for (int j = 0; j < n; j++) check(name, cap[inst][j], lit[4*(n-1-j) +: 4]);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_oe",  4'(oe_l),  4'h0);
    check("rst_qpi", 4'(qpi_w), 4'h0);
    check("rst_err", 4'(err_l), 4'h0);
    check("rst_dio", dio_o_l,   4'h0);
    chk_en  = 1'b1;
    reset_n = 1'b1;
    tick();

    // SPI write then read back
    do_write(24'h000010, 32'h11223344, 4, 1'b0, 4'h0);
    do_read(24'h000010, 4, 0);
    check_burst("spi_rd_lin",  0, 8, 32'h11223344);
    check_burst("spi_rd_wrap", 1, 8, 32'h11223344);

    // QPI entry, QPI read, QPI exit
    begin_txn(); send_cmd(8'h35); end_txn();
    check("qpi_on", 4'(qpi_l), 4'h1);
    do_read(24'h000010, 4, 0);
    check_burst("qpi_rd", 0, 8, 32'h11223344);
    begin_txn(); send_cmd(8'hF5); end_txn();
    check("qpi_off", 4'(qpi_l), 4'h0);

    // Wrapped vs linear burst from 0x13
    do_write(24'h000014, 32'h00005566, 2, 1'b0, 4'h0);
    do_read(24'h000013, 3, 0);
    check_burst("lin_cross", 0, 6, 32'h00445566);
    check_burst("wrap4",     1, 6, 32'h00441122);

    // Address bits above AW alias
    do_read(24'h001011, 2, 0);
    check_burst("alias", 0, 4, 32'h00002233);

    // Top of array: linear wraps to 0, wrapping device to 0xFFC
    do_write(24'h000FFF, 32'h00007788, 2, 1'b0, 4'h0);
    do_read(24'h000FFF, 2, 0);
    check_burst("top_lin",  0, 4, 32'h00007788);
    check_burst("top_wrap", 1, 4, 32'h00007788);
    do_read(24'h000000, 1, 0);
    check_burst("lin_zero", 0, 2, 32'h00000088);

    // Unsupported command, then a good read
    begin_txn();
    send_cmd(8'h03);
    repeat (20) sck_rise(4'($urandom));
    end_txn();
    check("err_set", 4'(err_l), 4'h1);
    do_read(24'h000010, 1, 0);
    check_burst("rd_after_err", 0, 2, 32'h00000011);
    check("err_sticky", 4'(err_w), 4'h1);

    // Write abort leaves the partial byte uncommitted
    do_write(24'h000021, 32'h0000005A, 1, 1'b0, 4'h0);
    do_write(24'h000020, 32'h000000AB, 1, 1'b1, 4'hC);
    do_read(24'h000020, 2, 0);
    check_burst("abort", 0, 4, 32'h0000AB5A);

    // Reset mid-read in QPI mode, array survives
    begin_txn(); send_cmd(8'h35); end_txn();
    do_read(24'h000010, 4, 3);
    check("rst_err_clr", 4'(err_l), 4'h0);
    do_read(24'h000010, 4, 0);
    check_burst("reread", 0, 8, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
